// File: rtl/fixed_point_divider_if.sv
// Handshake and data bundle for the fixed-point divider.
// The master drives the request side; the slave (the divider) drives the results.
interface fixed_point_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] o_quot;
  logic [WIDTH-1:0] o_rem;
  logic             o_busy;
  logic             o_done;
  logic             o_valid;
  logic             o_dbz;
  logic             o_ovf;

  modport master (
    output i_start, i_a, i_b,
    input  o_quot, o_rem, o_busy, o_done, o_valid, o_dbz, o_ovf
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_quot, o_rem, o_busy, o_done, o_valid, o_dbz, o_ovf
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential fixed-point divider: restoring radix-2 division on magnitudes,
// one quotient bit per cycle over WIDTH+FBITS cycles, signs, rounding and
// saturation applied in a final cycle.
module fixed_point_divider #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FBITS  = 4,
  parameter bit          SIGNED = 1'b1,
  parameter bit          ROUND  = 1'b0
) (
  input logic                 i_clk,
  input logic                 i_rst,
  fixed_point_divider_if.slave bus
);

  localparam int unsigned QW  = WIDTH + FBITS;
  localparam int unsigned QW1 = QW + 1;
  localparam int unsigned CW  = $clog2(QW + 1);
  localparam logic [CW-1:0] LastIter = CW'(QW - 1);

  // Bounds on the rounded quotient magnitude, expressed in QW+1 bits.
  localparam logic [QW:0] PosMaxSigned = {{(FBITS + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [QW:0] NegMaxSigned = {{(FBITS + 1){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [QW:0] MaxUnsigned  = {{(FBITS + 1){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFinal} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [QW-1:0]    num;   // dividend bits shift out of the top, quotient bits shift in
  logic [WIDTH-1:0] part;  // partial remainder, always < divisor magnitude
  logic [WIDTH-1:0] dvs;   // divisor magnitude
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             valid;
  logic             dbz;
  logic             ovf;

  assign bus.o_quot  = quot;
  assign bus.o_rem   = rem;
  assign bus.o_busy  = busy;
  assign bus.o_done  = done;
  assign bus.o_valid = valid;
  assign bus.o_dbz   = dbz;
  assign bus.o_ovf   = ovf;

  // Operand magnitudes and signs taken straight from the request inputs.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [QW-1:0]    num_init;

  // Decode signs and magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_neg    = SIGNED && bus.i_a[WIDTH-1];
    b_neg    = SIGNED && bus.i_b[WIDTH-1];
    a_mag    = a_neg ? (WIDTH'(0) - bus.i_a) : bus.i_a;
    b_mag    = b_neg ? (WIDTH'(0) - bus.i_b) : bus.i_b;
    num_init = QW'(a_mag) << FBITS;
  end

  // One restoring-division step.
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] part_nx;
  logic [QW-1:0]    num_nx;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    trial   = {part, num[QW-1]};
    fits    = (trial >= {1'b0, dvs});
    part_nx = fits ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
    num_nx  = {num[QW-2:0], fits};
  end

  // Final-stage result formation.
  logic [WIDTH:0]   rem2;
  logic             rnd_up;
  logic [QW:0]      q_rnd;
  logic [QW:0]      q_lim;
  logic             over;
  logic [WIDTH-1:0] q_lo;
  logic [WIDTH-1:0] q_sat;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;

  // Round, range-check, saturate and apply signs to the finished magnitudes.
  always_comb begin
    rem2   = {part, 1'b0};
    rnd_up = ROUND && (rem2 >= {1'b0, dvs});
    q_rnd  = {1'b0, num} + QW1'(rnd_up);
    if (SIGNED) begin
      q_lim = q_neg ? NegMaxSigned : PosMaxSigned;
      q_sat = q_neg ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end else begin
      q_lim = MaxUnsigned;
      q_sat = {WIDTH{1'b1}};
    end
    over     = (q_rnd > q_lim);
    q_lo     = q_rnd[WIDTH-1:0];
    quot_fin = over ? q_sat : (q_neg ? (WIDTH'(0) - q_lo) : q_lo);
    rem_fin  = r_neg ? (WIDTH'(0) - part) : part;
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= StIdle;
      cnt   <= '0;
      num   <= '0;
      part  <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.i_start) begin
            valid <= 1'b0;
            ovf   <= 1'b0;
            if (bus.i_b == '0) begin
              // Divide by zero completes immediately without iterating.
              dbz  <= 1'b1;
              done <= 1'b1;
              quot <= '0;
              rem  <= '0;
            end else begin
              dbz   <= 1'b0;
              busy  <= 1'b1;
              num   <= num_init;
              part  <= '0;
              dvs   <= b_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= '0;
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          num  <= num_nx;
          part <= part_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LastIter) begin
            state <= StFinal;
          end
        end
        StFinal: begin
          quot  <= quot_fin;
          rem   <= rem_fin;
          ovf   <= over;
          valid <= ~over;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider at WIDTH=16, FBITS=4, SIGNED=1,
// with one truncating and one rounding instance fed the same requests.
module tb_fixed_point_divider;

  logic i_clk;
  logic i_rst;

  int checks = 0;
  int errors = 0;

  fixed_point_divider_if #(.WIDTH(16)) bus_t ();
  fixed_point_divider_if #(.WIDTH(16)) bus_r ();

  fixed_point_divider #(
    .WIDTH (16),
    .FBITS (4),
    .SIGNED(1'b1),
    .ROUND (1'b0)
  ) u_dut_trunc (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus_t)
  );

  fixed_point_divider #(
    .WIDTH (16),
    .FBITS (4),
    .SIGNED(1'b1),
    .ROUND (1'b1)
  ) u_dut_round (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus_r)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus_t.i_a = a;
    bus_r.i_a = a;
    bus_t.i_b = b;
    bus_r.i_b = b;
    bus_t.i_start = s;
    bus_r.i_start = s;
  endtask

  // Issue one request; returns the number of edges after E0 until o_done is seen.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit mid_pulse,
                         output int cycles);
    @(negedge i_clk);
    drive(a, b, 1'b1);
    @(posedge i_clk);
    #1;
    drive(a, b, 1'b0);
    cycles = 0;
    while (!bus_t.o_done && cycles < 100) begin
      if (mid_pulse && cycles == 5) drive(16'd208, 16'd64, 1'b1);
      else drive(a, b, 1'b0);
      @(posedge i_clk);
      #1;
      cycles++;
    end
    drive(a, b, 1'b0);
    if (!bus_t.o_done) check("done_timeout", 32'(bus_t.o_done), 32'd1);
  endtask

  int  cyc;
  bit  seen_done;

  initial begin
    i_rst = 1'b1;
    drive(16'd0, 16'd0, 1'b0);
    #12;
    check("rst_quot",  32'(bus_t.o_quot),  32'd0);
    check("rst_rem",   32'(bus_t.o_rem),   32'd0);
    check("rst_busy",  32'(bus_t.o_busy),  32'd0);
    check("rst_done",  32'(bus_t.o_done),  32'd0);
    check("rst_valid", 32'(bus_t.o_valid), 32'd0);
    check("rst_flags", 32'({bus_t.o_dbz, bus_t.o_ovf}), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // 13.0 / 4.0, latency and busy profile.
    @(negedge i_clk);
    drive(16'd208, 16'd64, 1'b1);
    @(posedge i_clk);
    #1;
    drive(16'd208, 16'd64, 1'b0);
    check("busy_after_start", 32'(bus_t.o_busy), 32'd1);
    cyc = 0;
    while (!bus_t.o_done && cyc < 100) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check("lat_13_4",   32'(cyc),           32'd21);
    check("quot_13_4",  32'(bus_t.o_quot),  32'd52);
    check("rem_13_4",   32'(bus_t.o_rem),   32'd0);
    check("valid_13_4", 32'(bus_t.o_valid), 32'd1);
    check("busy_done",  32'(bus_t.o_busy),  32'd0);
    @(posedge i_clk);
    #1;
    check("done_width", 32'(bus_t.o_done),  32'd0);
    check("hold_quot",  32'(bus_t.o_quot),  32'd52);

    // 13.0 / 7.0: truncate vs round.
    run_div(16'd208, 16'd112, 1'b0, cyc);
    check("quot_13_7_t", 32'(bus_t.o_quot), 32'd29);
    check("rem_13_7_t",  32'(bus_t.o_rem),  32'd80);
    check("quot_13_7_r", 32'(bus_r.o_quot), 32'd30);
    check("rem_13_7_r",  32'(bus_r.o_rem),  32'd80);

    // -7.0625 / 2.0: negative quotient and remainder.
    run_div(16'hFF8F, 16'd32, 1'b0, cyc);
    check("quot_neg_t", 32'(bus_t.o_quot), 32'h0000_FFC8);
    check("rem_neg_t",  32'(bus_t.o_rem),  32'h0000_FFF0);
    check("quot_neg_r", 32'(bus_r.o_quot), 32'h0000_FFC7);
    check("valid_neg",  32'(bus_t.o_valid), 32'd1);

    // 2.0 / 0.0: divide by zero.
    run_div(16'd32, 16'd0, 1'b0, cyc);
    check("lat_dbz",   32'(cyc),           32'd0);
    check("dbz_flag",  32'(bus_t.o_dbz),   32'd1);
    check("dbz_valid", 32'(bus_t.o_valid), 32'd0);
    check("dbz_quot",  32'(bus_t.o_quot),  32'd0);
    check("dbz_rem",   32'(bus_t.o_rem),   32'd0);
    check("dbz_ovf",   32'(bus_t.o_ovf),   32'd0);
    check("dbz_busy",  32'(bus_t.o_busy),  32'd0);

    run_div(16'd208, 16'd64, 1'b0, cyc);
    check("quot_after_dbz", 32'(bus_t.o_quot), 32'd52);
    check("dbz_cleared",    32'(bus_t.o_dbz),  32'd0);

    // -2048.0 / -0.0625 overflows; a start pulsed mid-operation is ignored.
    run_div(16'h8000, 16'hFFFF, 1'b1, cyc);
    check("lat_ovf",   32'(cyc),           32'd21);
    check("ovf_flag",  32'(bus_t.o_ovf),   32'd1);
    check("ovf_valid", 32'(bus_t.o_valid), 32'd0);
    check("ovf_quot",  32'(bus_t.o_quot),  32'd32767);
    check("ovf_rem",   32'(bus_t.o_rem),   32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk);
      #1;
      if (bus_t.o_done || bus_t.o_busy) seen_done = 1'b1;
    end
    check("mid_start_ignored", 32'(seen_done),    32'd0);
    check("ovf_hold_quot",     32'(bus_t.o_quot), 32'd32767);

    // Reset 5 cycles into 6.0 / 2.0 aborts the operation.
    @(negedge i_clk);
    drive(16'd96, 16'd32, 1'b1);
    @(posedge i_clk);
    #1;
    drive(16'd96, 16'd32, 1'b0);
    repeat (5) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    check("abort_quot",  32'(bus_t.o_quot),  32'd0);
    check("abort_rem",   32'(bus_t.o_rem),   32'd0);
    check("abort_busy",  32'(bus_t.o_busy),  32'd0);
    check("abort_valid", 32'(bus_t.o_valid), 32'd0);
    check("abort_flags", 32'({bus_t.o_dbz, bus_t.o_ovf, bus_t.o_done}), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk);
      #1;
      if (bus_t.o_done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    run_div(16'd96, 16'd32, 1'b0, cyc);
    check("rerun_quot",  32'(bus_t.o_quot),  32'd48);
    check("rerun_valid", 32'(bus_t.o_valid), 32'd1);
    check("rerun_lat",   32'(cyc),           32'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand, quotient and remainder width in bits.
REQ-002 The block SHALL have parameter FBITS, default 4: fractional bits of i_a, i_b and o_quot (Q(WIDTH-FBITS).FBITS), 0 <= FBITS < WIDTH.
REQ-003 The block SHALL have parameter SIGNED, default 1: 1 = two's-complement operands/results, 0 = unsigned.
REQ-004 The block SHALL have parameter ROUND, default 0: 0 = truncate toward zero, 1 = round half away from zero.
REQ-005 The block SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port i_start, input, 1 bit: request a division with the current i_a/i_b.
REQ-008 The block SHALL have port i_a, input, WIDTH bits: dividend, fixed point.
REQ-009 The block SHALL have port i_b, input, WIDTH bits: divisor, fixed point.
REQ-010 The block SHALL have port o_quot, output, WIDTH bits: quotient, fixed point, FBITS fractional bits.
REQ-011 The block SHALL have port o_rem, output, WIDTH bits: raw integer remainder of the extended division (REQ-016), sign of dividend.
REQ-012 The block SHALL have port o_busy, output, 1 bit: operation in progress.
REQ-013 The block SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port o_valid, output, 1 bit: o_quot/o_rem are a correct result.
REQ-015 The block SHALL have ports o_dbz and o_ovf, outputs, 1 bit each: divide-by-zero and quotient overflow flags.

Function
REQ-016 The block SHALL compute N = i_a * 2^FBITS (WIDTH+FBITS bits), q = N / i_b truncated toward zero, r = N - q*i_b.
REQ-017 The block SHALL use restoring radix-2 division on magnitudes; signs SHALL be applied in the final stage (quotient negative iff operand signs differ and SIGNED=1; remainder sign = dividend sign).
REQ-018 With ROUND=1, |q| SHALL be incremented by 1 when 2*|r| >= |i_b|; o_rem SHALL still report the truncated r.
REQ-019 FSM states SHALL be IDLE, CALC, FINAL; IDLE->CALC on i_start with i_b != 0; CALC->FINAL after exactly WIDTH+FBITS iteration cycles; FINAL->IDLE unconditionally.
REQ-020 i_a/i_b SHALL be sampled only on the edge where i_start is high in IDLE; i_start while o_busy=1 SHALL be ignored.
REQ-021 Latency: with start sampled at edge E0, o_done SHALL be high for the one cycle following edge E(WIDTH+FBITS+1) (21 cycles at defaults).
REQ-022 o_busy SHALL be high from the edge after E0 through the edge completing FINAL, and low in the o_done cycle.
REQ-023 Divide by zero (i_b == 0 at start): o_done, o_dbz SHALL pulse/assert in the cycle after E0; o_valid=0, o_ovf=0, o_quot=0, o_rem=0; no CALC cycles.
REQ-024 Overflow: if the final (rounded) quotient is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] (SIGNED=1) or [0, 2^WIDTH-1] (SIGNED=0), o_ovf=1, o_valid=0, o_quot SHALL saturate to the nearest bound; o_rem as REQ-016.
REQ-025 Normal completion: o_valid=1, o_dbz=0, o_ovf=0.
REQ-026 o_quot, o_rem, o_valid, o_dbz, o_ovf SHALL hold until the next accepted start, which SHALL clear o_valid/o_dbz/o_ovf at E0.
REQ-027 Most-negative dividend (-2^(WIDTH-1)) SHALL be handled without magnitude overflow (internal magnitude width >= WIDTH+FBITS unsigned).

Reset
REQ-028 While i_rst=1, asynchronously: state=IDLE, o_quot=0, o_rem=0, o_busy=0, o_done=0, o_valid=0, o_dbz=0, o_ovf=0.
REQ-029 Reset asserted mid-CALC SHALL abort the operation with no o_done pulse; the next start after release SHALL run normally.

Verification (WIDTH=16, FBITS=4, SIGNED=1)
REQ-030 13.0/4.0 (a=208, b=64), ROUND=0 -> o_quot=52, o_rem=0, o_valid=1, o_done exactly 21 cycles after start, one cycle wide.
REQ-031 13.0/7.0 (a=208, b=112) -> ROUND=0: o_quot=29, o_rem=80; ROUND=1: o_quot=30, o_rem=80.
REQ-032 -7.0625/2.0 (a=-113, b=32) -> ROUND=0: o_quot=-56, o_rem=-16; ROUND=1: o_quot=-57.
REQ-033 2.0/0.0 (a=32, b=0) -> o_dbz=1, o_valid=0, o_quot=0, o_done one cycle after start; following 13/4 -> o_quot=52, o_dbz=0.
REQ-034 -2048.0/-0.0625 (a=-32768, b=-1) -> o_ovf=1, o_valid=0, o_quot=32767; i_start pulsed mid-op ignored.
REQ-035 Reset pulse 5 cycles into 6.0/2.0 -> all outputs 0, no o_done; rerun 6.0/2.0 (a=96, b=32) -> o_quot=48.
